// File: rtl/rapid_pkg.sv
// Shared types and constants for the RAPID-X core.
// This file holds the MEM-stage control bundles, the fault and state encodings, and the funct3 legality helpers.
package rapid_pkg;

   localparam int XLEN = 32;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef struct packed {
      logic       mem;
      logic       iop;
      logic [2:0] fcs_opcode;
      logic [4:0] rd;
   } control_mem_s;

   typedef struct packed {
      logic [4:0] rd;
      logic       wen;
   } control_wb_s;

   typedef enum logic [1:0] {NONE, MISALIGNED, ILLEGAL, TIMEOUT} mem_fault_e;

   typedef enum logic [1:0] {IDLE, REQ, RESP} mem_state_e;

   function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
      if (is_store) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
   endfunction

   // The unsigned variants share their size with the signed ones, so only the low two bits of funct3 matter here.
   function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
      case (f3[1:0])
         2'b01:   return addr_lo[0];
         2'b10:   return addr_lo != 2'b00;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/load_align_extend.sv
// Load data alignment: the selected byte or halfword is moved down to bit 0.
// The result is then sign- or zero-extended according to funct3.
module load_align_extend
   import rapid_pkg::*;
(
   input  logic [XLEN-1:0] i_rdata,
   input  logic [1:0]      i_addr_lo,
   input  logic [2:0]      i_funct3,
   output logic [XLEN-1:0] o_result
);

   logic [XLEN-1:0] shifted;

   always_comb begin
      shifted  = i_rdata >> {i_addr_lo, 3'b000};
      o_result = shifted;
      case (i_funct3)
         F3_B:    o_result = {{24{shifted[7]}}, shifted[7:0]};
         F3_H:    o_result = {{16{shifted[15]}}, shifted[15:0]};
         F3_BU:   o_result = {24'd0, shifted[7:0]};
         F3_HU:   o_result = {16'd0, shifted[15:0]};
         default: o_result = shifted;
      endcase
   end

endmodule

// File: rtl/mem_access_stage.sv
// RAPID-X MEM stage: runs loads and stores over the req/gnt/rvalid data port.
// Every result, including faults and non-memory pass-through, reaches writeback as a one-cycle registered pulse.
module mem_access_stage
   import rapid_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_valid,
   output logic              o_ready,
   input  control_mem_s      i_control_signal,
   input  logic [XLEN-1:0]   i_rd_output,
   input  logic [XLEN-1:0]   i_memory_data,
   output logic              o_dmem_req,
   output logic              o_dmem_we,
   output logic [3:0]        o_dmem_be,
   output logic [XLEN-1:0]   o_dmem_addr,
   output logic [XLEN-1:0]   o_dmem_wdata,
   input  logic              i_dmem_gnt,
   input  logic              i_dmem_rvalid,
   input  logic [XLEN-1:0]   i_dmem_rdata,
   output logic              o_wb_valid,
   output logic [4:0]        o_wb_rd,
   output logic              o_wb_wen,
   output logic [XLEN-1:0]   o_wb_data,
   output logic              o_fault,
   output mem_fault_e        o_fault_cause
);

   localparam int               CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

   mem_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              iop_q, iop_d;
   logic [2:0]        f3_q, f3_d;
   logic [1:0]        addr_lo_q, addr_lo_d;
   logic              req_q, req_d;
   logic              we_q, we_d;
   logic [3:0]        be_q, be_d;
   logic [XLEN-1:0]   addr_q, addr_d;
   logic [XLEN-1:0]   wdata_q, wdata_d;
   logic              wb_valid_q, wb_valid_d;
   control_wb_s       wb_q, wb_d;
   logic [XLEN-1:0]   wb_data_q, wb_data_d;
   logic              fault_q, fault_d;
   mem_fault_e        cause_q, cause_d;

   logic [XLEN-1:0]   load_result;
   logic              accept;
   logic              expired;

   load_align_extend u_align (
      .i_rdata   (i_dmem_rdata),
      .i_addr_lo (addr_lo_q),
      .i_funct3  (f3_q),
      .o_result  (load_result)
   );

   assign accept  = i_valid && (state_q == IDLE);
   assign expired = (cnt_q == LIMIT);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      iop_d      = iop_q;
      f3_d       = f3_q;
      addr_lo_d  = addr_lo_q;
      req_d      = req_q;
      we_d       = we_q;
      be_d       = be_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      wb_valid_d = 1'b0;
      wb_d       = '{rd: wb_q.rd, wen: 1'b0};
      wb_data_d  = wb_data_q;
      fault_d    = 1'b0;
      cause_d    = NONE;

      case (state_q)
         IDLE: begin
            if (accept) begin
               iop_d     = i_control_signal.iop;
               f3_d      = i_control_signal.fcs_opcode;
               addr_lo_d = i_rd_output[1:0];
               wb_d.rd   = i_control_signal.rd;
               wb_data_d = i_rd_output;
               if (!i_control_signal.mem) begin
                  wb_valid_d = 1'b1;
                  wb_d.wen   = (i_control_signal.rd != 5'd0);
               end else if (!f3_legal(i_control_signal.iop, i_control_signal.fcs_opcode)) begin
                  wb_valid_d = 1'b1;
                  fault_d    = 1'b1;
                  cause_d    = ILLEGAL;
               end else if (is_misaligned(i_control_signal.fcs_opcode, i_rd_output[1:0])) begin
                  wb_valid_d = 1'b1;
                  fault_d    = 1'b1;
                  cause_d    = MISALIGNED;
               end else begin
                  state_d = REQ;
                  cnt_d   = '0;
                  req_d   = 1'b1;
                  we_d    = i_control_signal.iop;
                  addr_d  = {i_rd_output[XLEN-1:2], 2'b00};
                  case (i_control_signal.fcs_opcode[1:0])
                     2'b00: begin
                        be_d    = 4'b0001 << i_rd_output[1:0];
                        wdata_d = {4{i_memory_data[7:0]}};
                     end
                     2'b01: begin
                        be_d    = 4'b0011 << {i_rd_output[1], 1'b0};
                        wdata_d = {2{i_memory_data[15:0]}};
                     end
                     default: begin
                        be_d    = 4'b1111;
                        wdata_d = i_memory_data;
                     end
                  endcase
               end
            end
         end
         REQ: begin
            if (i_dmem_gnt) begin
               req_d = 1'b0;
               cnt_d = '0;
               if (iop_q) begin
                  state_d    = IDLE;
                  wb_valid_d = 1'b1;
               end else begin
                  state_d = RESP;
               end
            end else if (expired) begin
               req_d      = 1'b0;
               state_d    = IDLE;
               wb_valid_d = 1'b1;
               fault_d    = 1'b1;
               cause_d    = TIMEOUT;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RESP: begin
            if (i_dmem_rvalid) begin
               state_d    = IDLE;
               wb_valid_d = 1'b1;
               wb_data_d  = load_result;
               wb_d.wen   = (wb_q.rd != 5'd0);
            end else if (expired) begin
               state_d    = IDLE;
               wb_valid_d = 1'b1;
               fault_d    = 1'b1;
               cause_d    = TIMEOUT;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         iop_q      <= 1'b0;
         f3_q       <= 3'd0;
         addr_lo_q  <= 2'd0;
         req_q      <= 1'b0;
         we_q       <= 1'b0;
         be_q       <= 4'd0;
         addr_q     <= '0;
         wdata_q    <= '0;
         wb_valid_q <= 1'b0;
         wb_q       <= '0;
         wb_data_q  <= '0;
         fault_q    <= 1'b0;
         cause_q    <= NONE;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         iop_q      <= iop_d;
         f3_q       <= f3_d;
         addr_lo_q  <= addr_lo_d;
         req_q      <= req_d;
         we_q       <= we_d;
         be_q       <= be_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         wb_valid_q <= wb_valid_d;
         wb_q       <= wb_d;
         wb_data_q  <= wb_data_d;
         fault_q    <= fault_d;
         cause_q    <= cause_d;
      end
   end

   assign o_ready       = (state_q == IDLE);
   assign o_dmem_req    = req_q;
   assign o_dmem_we     = we_q;
   assign o_dmem_be     = be_q;
   assign o_dmem_addr   = addr_q;
   assign o_dmem_wdata  = wdata_q;
   assign o_wb_valid    = wb_valid_q;
   assign o_wb_rd       = wb_q.rd;
   assign o_wb_wen      = wb_q.wen;
   assign o_wb_data     = wb_data_q;
   assign o_fault       = fault_q;
   assign o_fault_cause = cause_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed testbench for mem_access_stage.
// Expected values are hand-computed, and the memory side is driven cycle by cycle.
module tb_mem_access_stage;
   import rapid_pkg::*;

   localparam int TO = 4;

   logic            i_clk = 1'b0;
   logic            i_rst_n;
   logic            i_valid;
   logic            o_ready;
   control_mem_s    i_control_signal;
   logic [31:0]     i_rd_output;
   logic [31:0]     i_memory_data;
   logic            o_dmem_req;
   logic            o_dmem_we;
   logic [3:0]      o_dmem_be;
   logic [31:0]     o_dmem_addr;
   logic [31:0]     o_dmem_wdata;
   logic            i_dmem_gnt;
   logic            i_dmem_rvalid;
   logic [31:0]     i_dmem_rdata;
   logic            o_wb_valid;
   logic [4:0]      o_wb_rd;
   logic            o_wb_wen;
   logic [31:0]     o_wb_data;
   logic            o_fault;
   mem_fault_e      o_fault_cause;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 i_clk = ~i_clk;

   mem_access_stage #(.TIMEOUT_CYCLES(TO)) dut (
      .i_clk            (i_clk),
      .i_rst_n          (i_rst_n),
      .i_valid          (i_valid),
      .o_ready          (o_ready),
      .i_control_signal (i_control_signal),
      .i_rd_output      (i_rd_output),
      .i_memory_data    (i_memory_data),
      .o_dmem_req       (o_dmem_req),
      .o_dmem_we        (o_dmem_we),
      .o_dmem_be        (o_dmem_be),
      .o_dmem_addr      (o_dmem_addr),
      .o_dmem_wdata     (o_dmem_wdata),
      .i_dmem_gnt       (i_dmem_gnt),
      .i_dmem_rvalid    (i_dmem_rvalid),
      .i_dmem_rdata     (i_dmem_rdata),
      .o_wb_valid       (o_wb_valid),
      .o_wb_rd          (o_wb_rd),
      .o_wb_wen         (o_wb_wen),
      .o_wb_data        (o_wb_data),
      .o_fault          (o_fault),
      .o_fault_cause    (o_fault_cause)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic send(input logic mem, input logic iop, input logic [2:0] f3,
                       input logic [4:0] rd, input logic [31:0] a, input logic [31:0] d);
      i_control_signal.mem        = mem;
      i_control_signal.iop        = iop;
      i_control_signal.fcs_opcode = f3;
      i_control_signal.rd         = rd;
      i_rd_output                 = a;
      i_memory_data               = d;
      i_valid                     = 1'b1;
      tick();
      i_valid = 1'b0;
   endtask

   task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] rs2, input logic [3:0] exp_be,
                           input logic [31:0] exp_addr, input logic [31:0] exp_wdata);
      send(1'b1, 1'b1, f3, 5'd0, a, rs2);
      check({tag, "_req"},   32'(o_dmem_req), 32'd1);
      check({tag, "_we"},    32'(o_dmem_we), 32'd1);
      check({tag, "_be"},    32'(o_dmem_be), 32'(exp_be));
      check({tag, "_addr"},  o_dmem_addr, exp_addr);
      check({tag, "_wdata"}, o_dmem_wdata, exp_wdata);
      check({tag, "_ready"}, 32'(o_ready), 32'd0);
      i_dmem_gnt = 1'b1;
      tick();
      i_dmem_gnt = 1'b0;
      check({tag, "_wbv"},   32'(o_wb_valid), 32'd1);
      check({tag, "_wen"},   32'(o_wb_wen), 32'd0);
      check({tag, "_fault"}, 32'(o_fault), 32'd0);
      check({tag, "_reqlo"}, 32'(o_dmem_req), 32'd0);
      check({tag, "_rdy"},   32'(o_ready), 32'd1);
   endtask

   task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [4:0] rd, input int gnt_delay, input logic [31:0] rdata,
                          input logic [31:0] exp_data, input logic exp_wen);
      send(1'b1, 1'b0, f3, rd, a, 32'h0);
      check({tag, "_req"},  32'(o_dmem_req), 32'd1);
      check({tag, "_we"},   32'(o_dmem_we), 32'd0);
      check({tag, "_addr"}, o_dmem_addr, {a[31:2], 2'b00});
      for (int k = 0; k < gnt_delay; k++) begin
         tick();
         check({tag, "_hold"}, 32'(o_dmem_req), 32'd1);
      end
      i_dmem_gnt = 1'b1;
      tick();
      i_dmem_gnt = 1'b0;
      check({tag, "_resp_req"}, 32'(o_dmem_req), 32'd0);
      check({tag, "_resp_wbv"}, 32'(o_wb_valid), 32'd0);
      i_dmem_rdata  = rdata;
      i_dmem_rvalid = 1'b1;
      tick();
      i_dmem_rvalid = 1'b0;
      check({tag, "_wbv"},  32'(o_wb_valid), 32'd1);
      check({tag, "_data"}, o_wb_data, exp_data);
      check({tag, "_wen"},  32'(o_wb_wen), 32'(exp_wen));
      check({tag, "_rd"},   32'(o_wb_rd), 32'(rd));
      check({tag, "_rdy"},  32'(o_ready), 32'd1);
   endtask

   task automatic do_fault(input string tag, input logic iop, input logic [2:0] f3,
                           input logic [31:0] a, input mem_fault_e exp_cause);
      send(1'b1, iop, f3, 5'd4, a, 32'h0);
      check({tag, "_wbv"},   32'(o_wb_valid), 32'd1);
      check({tag, "_fault"}, 32'(o_fault), 32'd1);
      check({tag, "_cause"}, 32'(o_fault_cause), 32'(exp_cause));
      check({tag, "_wen"},   32'(o_wb_wen), 32'd0);
      check({tag, "_req"},   32'(o_dmem_req), 32'd0);
      check({tag, "_rdy"},   32'(o_ready), 32'd1);
   endtask

   task automatic wait_timeout(input string tag);
      int k;
      k = 0;
      for (int i = 1; i <= 12; i++) begin
         tick();
         if (o_wb_valid) begin
            k = i;
            break;
         end
      end
      check({tag, "_cycles"}, 32'(k), 32'(TO));
      check({tag, "_fault"},  32'(o_fault), 32'd1);
      check({tag, "_cause"},  32'(o_fault_cause), 32'(TIMEOUT));
      check({tag, "_wen"},    32'(o_wb_wen), 32'd0);
      check({tag, "_req"},    32'(o_dmem_req), 32'd0);
      check({tag, "_rdy"},    32'(o_ready), 32'd1);
   endtask

   initial begin
      i_rst_n          = 1'b0;
      i_valid          = 1'b0;
      i_control_signal = '0;
      i_rd_output      = '0;
      i_memory_data    = '0;
      i_dmem_gnt       = 1'b0;
      i_dmem_rvalid    = 1'b0;
      i_dmem_rdata     = '0;
      #12;
      check("rst_req",   32'(o_dmem_req), 32'd0);
      check("rst_be",    32'(o_dmem_be), 32'd0);
      check("rst_addr",  o_dmem_addr, 32'd0);
      check("rst_wbv",   32'(o_wb_valid), 32'd0);
      check("rst_wdata", o_wb_data, 32'd0);
      check("rst_fault", 32'(o_fault), 32'd0);
      check("rst_cause", 32'(o_fault_cause), 32'(NONE));
      check("rst_ready", 32'(o_ready), 32'd1);
      i_rst_n = 1'b1;
      tick();

      // ALU pass-through
      send(1'b0, 1'b0, 3'd0, 5'd5, 32'h1234_5678, 32'h0);
      check("alu_wbv",  32'(o_wb_valid), 32'd1);
      check("alu_wen",  32'(o_wb_wen), 32'd1);
      check("alu_data", o_wb_data, 32'h1234_5678);
      check("alu_rd",   32'(o_wb_rd), 32'd5);
      check("alu_req",  32'(o_dmem_req), 32'd0);
      tick();
      check("alu_pulse", 32'(o_wb_valid), 32'd0);
      send(1'b0, 1'b0, 3'd0, 5'd0, 32'hCAFE_0001, 32'h0);
      check("alu_x0_wen", 32'(o_wb_wen), 32'd0);

      do_store("sb", F3_B, 32'h0000_1003, 32'hAABB_CCDD, 4'b1000, 32'h0000_1000, 32'hDDDD_DDDD);
      do_store("sh", F3_H, 32'h0000_0102, 32'h1234_ABCD, 4'b1100, 32'h0000_0100, 32'hABCD_ABCD);
      do_store("sw", F3_W, 32'h0000_0208, 32'h0BAD_F00D, 4'b1111, 32'h0000_0208, 32'h0BAD_F00D);

      do_load("lb",  F3_B,  32'h0000_2001, 5'd7, 2, 32'h0000_8000, 32'hFFFF_FF80, 1'b1);
      do_load("lbu", F3_BU, 32'h0000_2001, 5'd7, 2, 32'h0000_8000, 32'h0000_0080, 1'b1);
      do_load("lh",  F3_H,  32'h0000_2002, 5'd9, 0, 32'h8001_1234, 32'hFFFF_8001, 1'b1);
      do_load("lhu", F3_HU, 32'h0000_2002, 5'd9, 0, 32'h8001_1234, 32'h0000_8001, 1'b1);
      do_load("lw0", F3_W,  32'h0000_2004, 5'd0, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);

      do_fault("lw_mis", 1'b0, F3_W,  32'h0000_3002, MISALIGNED);
      do_fault("sh_mis", 1'b1, F3_H,  32'h0000_3001, MISALIGNED);
      do_fault("ld_ill", 1'b0, 3'b011, 32'h0000_3000, ILLEGAL);
      do_fault("st_ill", 1'b1, 3'b100, 32'h0000_3000, ILLEGAL);

      // timeout while waiting for gnt
      send(1'b1, 1'b0, F3_W, 5'd3, 32'h0000_5000, 32'h0);
      check("to_req_up", 32'(o_dmem_req), 32'd1);
      wait_timeout("to_req");

      // timeout while waiting for rvalid
      send(1'b1, 1'b0, F3_W, 5'd3, 32'h0000_4000, 32'h0);
      i_dmem_gnt = 1'b1;
      tick();
      i_dmem_gnt = 1'b0;
      wait_timeout("to_resp");

      // asynchronous reset in REQ, then a stray rvalid
      send(1'b1, 1'b0, F3_W, 5'd6, 32'h0000_6000, 32'h0);
      check("ar_req_up", 32'(o_dmem_req), 32'd1);
      #2;
      i_rst_n = 1'b0;
      #1;
      check("ar_req",   32'(o_dmem_req), 32'd0);
      check("ar_ready", 32'(o_ready), 32'd1);
      #2;
      i_rst_n = 1'b1;
      tick();
      i_dmem_rdata  = 32'h1111_2222;
      i_dmem_rvalid = 1'b1;
      tick();
      i_dmem_rvalid = 1'b0;
      check("stray_wbv0", 32'(o_wb_valid), 32'd0);
      tick();
      check("stray_wbv1", 32'(o_wb_valid), 32'd0);
      check("stray_rdy",  32'(o_ready), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
MEM stage of the RAPID-X core, directly downstream of execute. It consumes the execute control bundle, ALU result/effective address and store data. It runs loads and stores against the data-memory req/gnt/rvalid port, applying byte-lane alignment and sign/zero extension. It hands a registered result to writeback and passes non-memory results through with one cycle of latency.

Parameters:
TIMEOUT_CYCLES, 255, max cycles spent waiting in REQ or RESP before a bus-timeout fault; must be >= 1.

Ports:
i_clk  in  1  core clock
i_rst_n  in  1  asynchronous active-low reset
i_valid  in  1  execute result valid
o_ready  out  1  stage can accept; low = upstream stall
i_control_signal  in  control_mem_s  mem, iop (1=store), fcs_opcode (funct3), rd
i_rd_output  in  XLEN  ALU result, or effective address when mem=1
i_memory_data  in  XLEN  store data (rs2)
o_dmem_req  out  1  memory request
o_dmem_we  out  1  1=write
o_dmem_be  out  4  byte enables
o_dmem_addr  out  XLEN  word-aligned address {addr[31:2],2'b00}
o_dmem_wdata  out  XLEN  lane-replicated store data
i_dmem_gnt  in  1  request accepted
i_dmem_rvalid  in  1  read data valid
i_dmem_rdata  in  XLEN  read data
o_wb_valid  out  1  writeback entry valid (one-cycle pulse)
o_wb_rd  out  5  destination register
o_wb_wen  out  1  register-file write enable
o_wb_data  out  XLEN  writeback value
o_fault  out  1  exception pulse, coincident with o_wb_valid
o_fault_cause  out  mem_fault_e  NONE/MISALIGNED/ILLEGAL/TIMEOUT

Behaviour:
- Reset (async, i_rst_n=0): state=IDLE. All o_dmem_*, o_wb_* and o_fault are 0; o_fault_cause=NONE; timeout counter=0. Reset mid-transaction drops o_dmem_req immediately. A stale rvalid after reset is ignored.
- o_ready = (state==IDLE). Inputs are captured on i_valid && o_ready.
- FSM: IDLE, REQ, RESP.
- IDLE, non-mem op: next cycle o_wb_valid=1, o_wb_data=captured i_rd_output; stay IDLE. Latency 1.
- IDLE, mem op, aligned and legal: go to REQ. o_dmem_* are driven from registered values.
- REQ: o_dmem_req=1, held stable until i_dmem_gnt. On gnt: a store goes to IDLE and emits wb (wen=0) the next cycle; a load goes to RESP.
- RESP: on i_dmem_rvalid, align and extend the data, emit wb next cycle, go to IDLE. rvalid outside RESP is ignored; memory guarantees rvalid >= 1 cycle after gnt.
- Minimum latency with zero-wait memory: store 2 cycles, load 3 cycles, capture to o_wb_valid.
- Timeout: the counter resets on entry to REQ/RESP and increments each cycle waiting. At TIMEOUT_CYCLES it drops req, emits wb with wen=0, fault=1, cause=TIMEOUT, and returns to IDLE.
- Legal funct3: loads 000,001,010,100,101; stores 000,001,010. Any other value: no request, wb next cycle with fault=1, cause=ILLEGAL.
- Misaligned (halfword addr[0]=1; word addr[1:0]!=0): no request, wb next cycle with fault=1, cause=MISALIGNED, wen=0.
- Store lanes:
  - SB: be=4'b0001<<addr[1:0], wdata={4{rs2[7:0]}}
  - SH: be=4'b0011<<{addr[1],1'b0}, wdata={2{rs2[15:0]}}
  - SW: be=4'b1111, wdata=rs2
- Load: shift rdata right by 8*addr[1:0], then sign-extend (LB/LH) or zero-extend (LBU/LHU); LW passes through.
- o_wb_wen = o_wb_valid && !o_fault && !(mem && iop) && rd!=0. The decoder sets rd=0 for branches and stores.

Decomposition:
- rapid_pkg additions: control_wb_s (rd, wen), mem_fault_e, mem_state_e, funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
- One combinational sub-module: load_align_extend (rdata, addr[1:0], funct3 -> XLEN result).

Test Plan:
- ALU pass-through: i_rd_output=0x1234_5678, rd=5 -> one cycle later o_wb_valid=1, wen=1, data=0x1234_5678, no dmem_req.
- SB addr=0x1003, rs2=0xAABB_CCDD, gnt same cycle as req -> be=4'b1000, addr=0x1000, wdata=0xDDDD_DDDD, wb wen=0.
- LB addr=0x2001, rdata=0x0000_8000, gnt after 2 cycles, rvalid 1 cycle later -> wb data=0xFFFF_FF80. Same stimulus as LBU -> 0x0000_0080.
- LW addr=0x3002 -> no req, fault=1, cause=MISALIGNED, wen=0, o_ready high again the next cycle.
- LW with gnt but no rvalid, TIMEOUT_CYCLES=4 -> req drops, fault cause=TIMEOUT, FSM back in IDLE.
- Assert i_rst_n=0 while in REQ -> o_dmem_req=0 immediately. Then send a stray rvalid after reset -> no o_wb_valid.
